// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: logic/arith in one cycle, serial shifts and multiply.
// Define ALU_EXEC_MUL_EN to build the iterative shift-add multiplier for code 1000.
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] K_SLL = 2'd0;
    localparam logic [1:0] K_SRL = 2'd1;
    localparam logic [1:0] K_SRA = 2'd2;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [1:0] K_MUL = 2'd3;
`endif

    logic [1:0]      state;
    logic [1:0]      kind_q;
    logic [SHW-1:0]  count;
    logic [XLEN-1:0] res_q;
    logic            ill_q;

    logic            dec_single;
    logic            dec_shift;
    logic            dec_mul;
    logic [1:0]      dec_kind;
    logic [XLEN-1:0] single_res;
    logic [SHW-1:0]  shamt;

    logic [1:0]      sh_kind;
    logic [XLEN-1:0] sh_src;
    logic [XLEN-1:0] sh_one;

`ifdef ALU_EXEC_MUL_EN
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplr;
    logic [XLEN-1:0] mul_acc;

    always_comb mul_acc = res_q + (mplr[0] ? mcand : '0);
`endif

    assign shamt = op_b[SHW-1:0];

    always_comb begin
        dec_single = 1'b0;
        dec_shift  = 1'b0;
        dec_mul    = 1'b0;
        dec_kind   = K_SLL;
        single_res = '0;
        unique case (alu_ctrl)
            4'b0000: begin dec_single = 1'b1; single_res = op_a & op_b; end
            4'b0001: begin dec_single = 1'b1; single_res = op_a | op_b; end
            4'b0010: begin dec_single = 1'b1; single_res = op_a + op_b; end
            4'b0110: begin dec_single = 1'b1; single_res = op_a - op_b; end
            4'b0111: begin
                dec_single = 1'b1;
                single_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            end
            4'b0011: begin dec_shift = 1'b1; dec_kind = K_SLL; end
            4'b0100: begin dec_shift = 1'b1; dec_kind = K_SRL; end
            4'b0101: begin dec_shift = 1'b1; dec_kind = K_SRA; end
`ifdef ALU_EXEC_MUL_EN
            4'b1000: begin dec_mul = 1'b1; dec_kind = K_MUL; end
`endif
            default: ;
        endcase
    end

    // The accept edge performs the first shift step, so a shift by N finishes in N cycles.
    always_comb begin
        sh_kind = (state == S_IDLE) ? dec_kind : kind_q;
        sh_src  = (state == S_IDLE) ? op_a : res_q;
        unique case (sh_kind)
            K_SLL:   sh_one = sh_src << 1;
            K_SRL:   sh_one = sh_src >> 1;
            default: sh_one = {sh_src[XLEN-1], sh_src[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            kind_q <= K_SLL;
            count  <= '0;
            res_q  <= '0;
            ill_q  <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            mcand  <= '0;
            mplr   <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        kind_q <= dec_kind;
                        ill_q  <= !(dec_single || dec_shift || dec_mul);
                        res_q  <= single_res;
                        state  <= S_DONE;
                        if (dec_shift) begin
                            res_q <= (shamt == '0) ? op_a : sh_one;
                            count <= shamt - SHW'(1);
                            if (shamt > SHW'(1)) state <= S_BUSY;
                        end
`ifdef ALU_EXEC_MUL_EN
                        if (dec_mul) begin
                            res_q <= op_b[0] ? op_a : '0;
                            mcand <= op_a << 1;
                            mplr  <= op_b >> 1;
                            count <= SHW'(XLEN - 1);
                            state <= S_BUSY;
                        end
`endif
                    end
                end
                S_BUSY: begin
                    count <= count - SHW'(1);
                    if (count == SHW'(1)) state <= S_DONE;
`ifdef ALU_EXEC_MUL_EN
                    if (kind_q == K_MUL) begin
                        res_q <= mul_acc;
                        mcand <= mcand << 1;
                        mplr  <= mplr >> 1;
                    end else begin
                        res_q <= sh_one;
                    end
`else
                    res_q <= sh_one;
`endif
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign result    = res_q;
    assign zero      = (res_q == '0);
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: random and directed ops checked
// against a plain-arithmetic reference model, including result latency.
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = 4'h0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_checks = 0;
    int n_fail = 0;
    bit rnd_rdy = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        longint      t_valid;
    } exp_t;

    exp_t   sb[$];
    exp_t   m_e;
    longint first_t = 0;
    bit     seen = 1'b0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: spec rules in plain arithmetic; lat = cycles from accept to out_valid.
    function automatic void model(input logic [3:0] c, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        r   = '0;
        ill = 1'b0;
        lat = 1;
        case (c)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a + b;
            4'h6: r = a - b;
            4'h7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h3: r = a << sh;
            4'h4: r = a >> sh;
            4'h5: r = $unsigned($signed(a) >>> sh);
`ifdef ALU_EXEC_MUL_EN
            4'h8: begin r = a * b; lat = XLEN; end
`endif
            default: ill = 1'b1;
        endcase
        if (c == 4'h3 || c == 4'h4 || c == 4'h5) lat = (sh == 0) ? 1 : sh;
    endfunction

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        int   waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        model(c, a, b, e.res, e.ill, lat);
        e.t_valid = longint'($time) + 10 * lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: outstanding=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!out_valid) begin
            seen = 1'b0;
        end else begin
            if (!seen) begin
                seen    = 1'b1;
                first_t = longint'($time);
            end
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else if (out_ready) begin
                m_e = sb.pop_front();
                chk("result", result, m_e.res);
                chk("zero", 32'(zero), 32'(m_e.res == 0));
                chk("illegal", 32'(illegal), 32'(m_e.ill));
                chk("latency_time", 32'(first_t), 32'(m_e.t_valid));
            end else begin
                chk("hold_result", result, sb[0].res);
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            out_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_zero"}, 32'(zero), 32'd1);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    logic [3:0] legal_codes [9];

    initial begin
        legal_codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h3, 4'h4, 4'h5, 4'h8};
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        issue(4'h2, 32'h0000_0005, 32'hFFFF_FFFB);
        issue(4'h6, 32'd3, 32'd5);
        issue(4'h7, 32'hFFFF_FFFF, 32'd1);
        issue(4'h5, 32'h8000_0000, 32'h0000_0024);
        issue(4'h5, 32'h8000_0000, 32'h0000_0020);
        drain();

        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(4'h0, 32'hF0F0_1234, 32'h0FF0_FFFF);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            alu_ctrl = 4'h2;
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);

        issue(4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(4'h8, 32'd7, 32'd6);
        drain();

        issue(4'h3, 32'h0000_0ABC, 32'd20);
        repeat (9) @(posedge clk);
        #1;
        sb.delete();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("midop_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        issue(4'h1, 32'h0000_00F0, 32'h0000_000F);
        drain();

        rnd_rdy = 1'b1;
        repeat (60) begin
            int         r;
            logic [3:0] c;
            logic [31:0] b;
            r = $urandom_range(9);
            c = (r == 9) ? 4'($urandom) : legal_codes[r];
            b = (r % 3 == 0) ? 32'($urandom_range(3)) : $urandom;
            issue(c, $urandom, b);
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
